gift_round_sequencer: RTL and testbench
=======================================

GIFT_ROUND_SEQUENCER -- requirements
Module: gift_round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 40, total GIFT rounds (28 for GIFT-64, 40 for GIFT-128) SHALL be supported.
REQ-002 Parameter UNROLL, default 1, rounds per clock; ITER = ROUNDS/UNROLL SHALL be the derived iteration count.
REQ-003 inClk  in  1  sole clock; all logic on rising edge.
REQ-004 inRst  in  1  reset, synchronous, active-high.
REQ-005 inExtKeyWr  in  1  host key-load strobe.
REQ-006 inExtDataWr  in  1  host data-load / start strobe.
REQ-007 inMode  in  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-008 inOutReady  in  1  downstream accepts result.
REQ-009 outIntKeyschRegExtWr  out  1  key register load from host.
REQ-010 outIntKeyschRegIntWr  out  1  key register update from key schedule.
REQ-011 outKeyschInv  out  1  key schedule direction, 0 forward, 1 inverse.
REQ-012 outIntRoundRegExtWr / outIntRoundRegIntWr  out  1 each  state register load from host / from round logic.
REQ-013 outRoundIdx  out  clog2(ROUNDS)  index of first round in current iteration (round-constant select).
REQ-014 outIntDataOutRegWr  out  1  output register capture strobe.
REQ-015 outValid, outBusy, outKeyLoaded  out  1 each  result valid / operation in progress / key present and unused.

Function
REQ-016 States SHALL be IDLE, KEYPREP, RUN, CAPTURE, VALID; iteration counter ITER-wide, 0..ITER-1.
REQ-017 IDLE: outIntKeyschRegExtWr = inExtKeyWr; outIntRoundRegExtWr = inExtDataWr; all other strobes 0; outBusy 0.
REQ-018 Key write in IDLE SHALL set outKeyLoaded the next cycle; key strobes in any other state SHALL be ignored.
REQ-019 Start = inExtDataWr in IDLE with outKeyLoaded=1 or inExtKeyWr=1 same cycle; start SHALL latch inMode, clear outKeyLoaded, clear counter.
REQ-020 inExtDataWr outside IDLE, or in IDLE with no key, SHALL be ignored (no register strobes, no state change).
REQ-021 Encrypt start -> RUN; decrypt start -> KEYPREP.
REQ-022 KEYPREP: ITER cycles, outIntKeyschRegIntWr=1, outKeyschInv=0, round-register strobes 0; then RUN.
REQ-023 RUN: ITER cycles, outIntRoundRegIntWr=1, outIntKeyschRegIntWr=1, outKeyschInv=mode; outRoundIdx = c*UNROLL (encrypt) or (ITER-1-c)*UNROLL (decrypt), c = counter.
REQ-024 After last RUN cycle -> CAPTURE: one cycle, outIntDataOutRegWr=1, no key/round strobes; then VALID.
REQ-025 VALID: outValid=1 held until inOutReady=1, then IDLE next cycle; inOutReady ignored in all other states.
REQ-026 outBusy SHALL be 1 in KEYPREP, RUN, CAPTURE, VALID.
REQ-027 Encrypt latency: start at cycle T -> outIntDataOutRegWr at T+ITER+1, outValid from T+ITER+2; decrypt adds ITER cycles.
REQ-028 Counter SHALL saturate-free wrap to 0 on each state exit; outRoundIdx SHALL be 0 outside RUN.
REQ-029 Decrypt leaves key register at its loaded value; encrypt leaves it advanced, hence key reload required (outKeyLoaded=0).

Reset
REQ-030 inRst SHALL take priority over all inputs, in any state, including mid-RUN.
REQ-031 On reset: state IDLE, counter 0, mode 0, outKeyLoaded 0, all outputs 0 (outIntKeyschRegExtWr/outIntRoundRegExtWr follow REQ-017 only after reset deasserts).
REQ-032 Strobes asserted in the reset cycle SHALL have no effect.

Structure
REQ-033 Shared package gift_pkg SHALL hold state enum, mode encoding, GIFT64_ROUNDS=28, GIFT128_ROUNDS=40.
REQ-034 Elaboration SHALL fail if ROUNDS mod UNROLL != 0 or UNROLL < 1.
REQ-035 One sub-module gift_iter_counter (clear, enable, terminal flag at ITER-1) SHALL be instantiated; FSM stays in top.

Verification
REQ-036 ROUNDS=40, UNROLL=1: key+start same cycle T, encrypt -> 40 RUN cycles idx 0..39, outIntDataOutRegWr at T+41, outValid T+42.
REQ-037 ROUNDS=28, UNROLL=4, decrypt -> 7 KEYPREP, 7 RUN with idx 24,20,...,0, outKeyschInv=1 in RUN, outValid at T+16.
REQ-038 Start with outKeyLoaded=0 and no key strobe -> no strobes, outBusy stays 0.
REQ-039 inOutReady=0 for 5 cycles in VALID -> outValid held 5 cycles; start strobes during VALID ignored; ready=1 -> IDLE next cycle.
REQ-040 inRst at RUN cycle 17 -> next cycle all outputs 0, IDLE, outKeyLoaded 0; subsequent start without key ignored.
REQ-041 Two back-to-back decrypts with single key load -> second start rejected (key consumed); reload key -> identical strobe trace.

Source files
------------

// File: rtl/gift_pkg.sv
// Shared types and constants for the GIFT round sequencer slice.
// Holds the state encoding, the cipher direction encoding and the standard round counts.
package gift_pkg;

  localparam int GIFT64_ROUNDS  = 28;
  localparam int GIFT128_ROUNDS = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYPREP = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_VALID   = 3'd4
  } seq_state_e;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Width needed to count 0..n-1, never narrower than one bit
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gift_round_sequencer_if.sv
// Host/datapath handshake bundle of the GIFT round sequencer.
// The master side is the host plus datapath, the slave side is the sequencer.
interface gift_round_sequencer_if
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT128_ROUNDS
);

  localparam int IDX_W = cntWidth(ROUNDS);

  logic             inExtKeyWr;
  logic             inExtDataWr;
  logic             inMode;
  logic             inOutReady;
  logic             outIntKeyschRegExtWr;
  logic             outIntKeyschRegIntWr;
  logic             outKeyschInv;
  logic             outIntRoundRegExtWr;
  logic             outIntRoundRegIntWr;
  logic [IDX_W-1:0] outRoundIdx;
  logic             outIntDataOutRegWr;
  logic             outValid;
  logic             outBusy;
  logic             outKeyLoaded;

  modport master (
    output inExtKeyWr, inExtDataWr, inMode, inOutReady,
    input  outIntKeyschRegExtWr, outIntKeyschRegIntWr, outKeyschInv,
           outIntRoundRegExtWr, outIntRoundRegIntWr, outRoundIdx,
           outIntDataOutRegWr, outValid, outBusy, outKeyLoaded
  );

  modport slave (
    input  inExtKeyWr, inExtDataWr, inMode, inOutReady,
    output outIntKeyschRegExtWr, outIntKeyschRegIntWr, outKeyschInv,
           outIntRoundRegExtWr, outIntRoundRegIntWr, outRoundIdx,
           outIntDataOutRegWr, outValid, outBusy, outKeyLoaded
  );

endinterface

// File: rtl/gift_iter_counter.sv
// Iteration counter for the round sequencer: counts 0..ITER-1 and wraps to 0.
// outLast flags the final iteration so the FSM can leave its current phase.
module gift_iter_counter
  import gift_pkg::*;
#(
  parameter int ITER = 40,
  localparam int CW  = cntWidth(ITER)
) (
  input  logic          inClk,
  input  logic          inRst,
  input  logic          inClear,
  input  logic          inEnable,
  output logic [CW-1:0] outCount,
  output logic          outLast
);

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [CW-1:0] count_q, count_d;

  // Wrapping on the terminal value leaves the counter at 0 for the next phase
  always_comb begin
    count_d = count_q;
    if (inClear) begin
      count_d = '0;
    end else if (inEnable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign outCount = count_q;
  assign outLast  = (count_q == LAST);

endmodule

// File: rtl/gift_round_sequencer.sv
// Control FSM for an iterative GIFT core: key preparation for decryption,
// round iterations, output capture and a valid/ready result handshake.
module gift_round_sequencer
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT128_ROUNDS,
  parameter int UNROLL = 1
) (
  input  logic                   inClk,
  input  logic                   inRst,
  gift_round_sequencer_if.slave  bus
);

  localparam int ITER  = (UNROLL > 0) ? (ROUNDS / UNROLL) : 1;
  localparam int CW    = cntWidth(ITER);
  localparam int IDX_W = cntWidth(ROUNDS);

  generate
    if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : gParamCheck
      $error("gift_round_sequencer: ROUNDS must be a positive multiple of UNROLL");
    end
  endgenerate

  seq_state_e    state_q, state_d;
  mode_e         mode_q, mode_d;
  logic          keyLoaded_q, keyLoaded_d;
  logic          cntClear, cntEnable, cntLast;
  logic [CW-1:0] cntValue;
  logic          start;
  logic [31:0]   iterSel;

  gift_iter_counter #(
    .ITER (ITER)
  ) uIterCounter (
    .inClk    (inClk),
    .inRst    (inRst),
    .inClear  (cntClear),
    .inEnable (cntEnable),
    .outCount (cntValue),
    .outLast  (cntLast)
  );

  // Decryption walks the round constants backwards from the last iteration
  always_comb begin
    iterSel = (mode_q == MODE_DEC) ? (32'(ITER - 1) - 32'(cntValue)) : 32'(cntValue);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    keyLoaded_d = keyLoaded_q;
    cntClear    = 1'b0;
    cntEnable   = 1'b0;
    start       = 1'b0;

    bus.outIntKeyschRegExtWr = 1'b0;
    bus.outIntKeyschRegIntWr = 1'b0;
    bus.outKeyschInv         = 1'b0;
    bus.outIntRoundRegExtWr  = 1'b0;
    bus.outIntRoundRegIntWr  = 1'b0;
    bus.outRoundIdx          = '0;
    bus.outIntDataOutRegWr   = 1'b0;
    bus.outValid             = 1'b0;
    bus.outBusy              = 1'b0;
    bus.outKeyLoaded         = keyLoaded_q;

    unique case (state_q)
      ST_IDLE: begin
        // A key arriving together with the data strobe is enough to start
        start                    = bus.inExtDataWr && (keyLoaded_q || bus.inExtKeyWr);
        bus.outIntKeyschRegExtWr = bus.inExtKeyWr && !inRst;
        bus.outIntRoundRegExtWr  = start && !inRst;
        if (start) begin
          mode_d      = mode_e'(bus.inMode);
          keyLoaded_d = 1'b0;
          cntClear    = 1'b1;
          state_d     = bus.inMode ? ST_KEYPREP : ST_RUN;
        end else if (bus.inExtKeyWr) begin
          keyLoaded_d = 1'b1;
        end
      end
      ST_KEYPREP: begin
        bus.outBusy              = 1'b1;
        bus.outIntKeyschRegIntWr = 1'b1;
        cntEnable                = 1'b1;
        if (cntLast) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.outBusy              = 1'b1;
        bus.outIntRoundRegIntWr  = 1'b1;
        bus.outIntKeyschRegIntWr = 1'b1;
        bus.outKeyschInv         = (mode_q == MODE_DEC);
        bus.outRoundIdx          = IDX_W'(iterSel * 32'(UNROLL));
        cntEnable                = 1'b1;
        if (cntLast) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        bus.outBusy            = 1'b1;
        bus.outIntDataOutRegWr = 1'b1;
        cntClear               = 1'b1;
        state_d                = ST_VALID;
      end
      ST_VALID: begin
        bus.outBusy  = 1'b1;
        bus.outValid = 1'b1;
        if (bus.inOutReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ENC;
      keyLoaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      keyLoaded_q <= keyLoaded_d;
    end
  end

endmodule

// File: tb/tb_gift_round_sequencer.sv
// Bench for gift_round_sequencer: a GIFT-128 (UNROLL=1) and a GIFT-64 (UNROLL=4) instance
// share one stimulus stream and are both checked against an operation-schedule model.
module tb_gift_round_sequencer;
  import gift_pkg::*;

  typedef struct packed {
    logic       keyExt;
    logic       keyInt;
    logic       inv;
    logic       roundExt;
    logic       roundInt;
    logic       dout;
    logic       valid;
    logic       busy;
    logic       kl;
    logic [7:0] idx;
  } exp_t;

  typedef struct {
    bit k, d, m, r;
    bit expKeyExt, expRoundExt, expKl, expBusy;
  } vec_t;

  logic inClk = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   passes = 0;

  gift_round_sequencer_if #(.ROUNDS(GIFT128_ROUNDS)) ifA();
  gift_round_sequencer_if #(.ROUNDS(GIFT64_ROUNDS))  ifB();

  gift_round_sequencer #(.ROUNDS(GIFT128_ROUNDS), .UNROLL(1)) dutA (
    .inClk (inClk), .inRst (rst), .bus (ifA.slave)
  );
  gift_round_sequencer #(.ROUNDS(GIFT64_ROUNDS), .UNROLL(4)) dutB (
    .inClk (inClk), .inRst (rst), .bus (ifB.slave)
  );

  always #5 inClk = ~inClk;
  always @(posedge inClk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic applyStimulus(input bit k, input bit d, input bit m, input bit r, input bit rs = 1'b0);
    @(posedge inClk);
    #1;
    rst = rs;
    ifA.inExtKeyWr = k; ifA.inExtDataWr = d; ifA.inMode = m; ifA.inOutReady = r;
    ifB.inExtKeyWr = k; ifB.inExtDataWr = d; ifB.inMode = m; ifB.inOutReady = r;
    @(negedge inClk);
  endtask

  function automatic exp_t getAct(input int d);
    exp_t a;
    if (d == 0) begin
      a = '{ifA.outIntKeyschRegExtWr, ifA.outIntKeyschRegIntWr, ifA.outKeyschInv,
            ifA.outIntRoundRegExtWr, ifA.outIntRoundRegIntWr, ifA.outIntDataOutRegWr,
            ifA.outValid, ifA.outBusy, ifA.outKeyLoaded, 8'(ifA.outRoundIdx)};
    end else begin
      a = '{ifB.outIntKeyschRegExtWr, ifB.outIntKeyschRegIntWr, ifB.outKeyschInv,
            ifB.outIntRoundRegExtWr, ifB.outIntRoundRegIntWr, ifB.outIntDataOutRegWr,
            ifB.outValid, ifB.outBusy, ifB.outKeyLoaded, 8'(ifB.outRoundIdx)};
    end
    return a;
  endfunction

  // Model: an operation is an offset into a fixed schedule of
  // [ITER key-prep cycles if decrypting] [ITER round cycles] [1 capture cycle]
  int   mOff [2] = '{-1, -1};
  bit   mMode[2] = '{1'b0, 1'b0};
  bit   mWait[2] = '{1'b0, 1'b0};
  bit   mKl  [2] = '{1'b0, 1'b0};
  int   mIter, mUn, mPre, mO, mC;
  bit   mStart;
  exp_t mExp;

  always @(negedge inClk) begin
    for (int d = 0; d < 2; d++) begin
      mIter = (d == 0) ? 40 : 7;
      mUn   = (d == 0) ? 1 : 4;
      if (rst) begin
        mOff[d] = -1; mWait[d] = 1'b0; mKl[d] = 1'b0;
      end else begin
        mExp   = '0;
        mStart = 1'b0;
        mPre   = mMode[d] ? mIter : 0;
        if (mOff[d] >= 0) begin
          mO = mOff[d];
          mExp.busy = 1'b1;
          if (mO < mPre) begin
            mExp.keyInt = 1'b1;
          end else if (mO < mPre + mIter) begin
            mC = mO - mPre;
            mExp.keyInt   = 1'b1;
            mExp.roundInt = 1'b1;
            mExp.inv      = mMode[d];
            mExp.idx      = mMode[d] ? 8'((mIter - 1 - mC) * mUn) : 8'(mC * mUn);
          end else begin
            mExp.dout = 1'b1;
          end
        end else if (mWait[d]) begin
          mExp.valid = 1'b1;
          mExp.busy  = 1'b1;
        end else begin
          mStart        = ifA.inExtDataWr && (mKl[d] || ifA.inExtKeyWr);
          mExp.keyExt   = ifA.inExtKeyWr;
          mExp.roundExt = mStart;
        end
        mExp.kl = mKl[d];
        checkOutput($sformatf("model dut%0d cyc%0d", d, cyc), 32'(getAct(d)), 32'(mExp));
        if (mOff[d] >= 0) begin
          mOff[d]++;
          if (mOff[d] == mPre + mIter + 1) begin
            mOff[d] = -1; mWait[d] = 1'b1;
          end
        end else if (mWait[d]) begin
          if (ifA.inOutReady) mWait[d] = 1'b0;
        end else if (mStart) begin
          mOff[d] = 0; mMode[d] = ifA.inMode; mKl[d] = 1'b0;
        end else if (ifA.inExtKeyWr) begin
          mKl[d] = 1'b1;
        end
      end
    end
  end

  logic [31:0] traceCur[$];
  logic [31:0] trace1[$];

  // Starts an operation with an already loaded key and records dutB outputs up to its valid cycle
  task automatic captureOp(input bit m);
    bit seenB = 1'b0;
    traceCur.delete();
    applyStimulus(0, 1, m, 0);
    traceCur.push_back(32'(getAct(1)));
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (!seenB) traceCur.push_back(32'(getAct(1)));
      if (ifB.outValid) seenB = 1'b1;
      if (ifA.outValid && ifB.outValid) break;
    end
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
  endtask

  vec_t vecs[7];
  int   tStart, tD, tV, runCnt, firstIdx, lastIdx, nb, invCnt, kpCnt, diffs;
  int   bIdx[7];

  initial begin
    ifA.inExtKeyWr = 0; ifA.inExtDataWr = 0; ifA.inMode = 0; ifA.inOutReady = 0;
    ifB.inExtKeyWr = 0; ifB.inExtDataWr = 0; ifB.inMode = 0; ifB.inOutReady = 0;
    vecs[0] = '{0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0,  0, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 0,  1, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0,  0, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 1,  0, 0, 1, 0};
    vecs[5] = '{1, 0, 0, 0,  1, 0, 1, 0};
    vecs[6] = '{0, 0, 0, 0,  0, 0, 1, 0};

    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset valid A", 32'(ifA.outValid), 0);
    checkOutput("reset busy B", 32'(ifB.outBusy), 0);
    checkOutput("reset keyLoaded A", 32'(ifA.outKeyLoaded), 0);
    checkOutput("reset idx A", 32'(ifA.outRoundIdx), 0);

    $display("[TB] idle table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].k, vecs[i].d, vecs[i].m, vecs[i].r);
      checkOutput($sformatf("tbl%0d keyExt A", i), 32'(ifA.outIntKeyschRegExtWr), 32'(vecs[i].expKeyExt));
      checkOutput($sformatf("tbl%0d roundExt B", i), 32'(ifB.outIntRoundRegExtWr), 32'(vecs[i].expRoundExt));
      checkOutput($sformatf("tbl%0d keyLoaded A", i), 32'(ifA.outKeyLoaded), 32'(vecs[i].expKl));
      checkOutput($sformatf("tbl%0d busy B", i), 32'(ifB.outBusy), 32'(vecs[i].expBusy));
    end

    $display("[TB] encrypt with key and start in the same cycle");
    applyStimulus(1, 1, 0, 0);
    tStart = cyc; tD = -1; tV = -1; runCnt = 0; firstIdx = -1; lastIdx = -1;
    for (int i = 0; i < 100 && tV < 0; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (ifA.outIntRoundRegIntWr) begin
        if (runCnt == 0) firstIdx = int'(ifA.outRoundIdx);
        lastIdx = int'(ifA.outRoundIdx);
        runCnt++;
      end
      if (ifA.outIntDataOutRegWr) tD = cyc - tStart;
      if (ifA.outValid) tV = cyc - tStart;
    end
    checkOutput("enc A capture latency", 32'(tD), 41);
    checkOutput("enc A valid latency", 32'(tV), 42);
    checkOutput("enc A run cycles", 32'(runCnt), 40);
    checkOutput("enc A first idx", 32'(firstIdx), 0);
    checkOutput("enc A last idx", 32'(lastIdx), 39);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1, 0);
      checkOutput($sformatf("valid hold A %0d", i), 32'(ifA.outValid), 1);
      checkOutput($sformatf("valid hold roundExt A %0d", i), 32'(ifA.outIntRoundRegExtWr), 0);
    end
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after ready busy A", 32'(ifA.outBusy), 0);
    checkOutput("after ready keyLoaded A", 32'(ifA.outKeyLoaded), 0);

    $display("[TB] decrypt on the unrolled instance");
    applyStimulus(1, 1, 1, 0);
    tStart = cyc; tV = -1; nb = 0; invCnt = 0; kpCnt = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (ifB.outIntRoundRegIntWr) begin
        if (nb < 7) bIdx[nb] = int'(ifB.outRoundIdx);
        nb++;
        if (ifB.outKeyschInv) invCnt++;
      end
      if (ifB.outIntKeyschRegIntWr && !ifB.outIntRoundRegIntWr) kpCnt++;
      if (ifB.outValid && tV < 0) tV = cyc - tStart;
      if (ifA.outValid && ifB.outValid) break;
    end
    checkOutput("dec B valid latency", 32'(tV), 16);
    checkOutput("dec B keyprep cycles", 32'(kpCnt), 7);
    checkOutput("dec B run cycles", 32'(nb), 7);
    checkOutput("dec B inverse cycles", 32'(invCnt), 7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("dec B idx %0d", i), 32'(bIdx[i]), 32'((6 - i) * 4));
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(1, 1, 0, 0);
    repeat (16) applyStimulus(0, 0, 0, 0);
    checkOutput("pre-reset run A", 32'(ifA.outIntRoundRegIntWr), 1);
    applyStimulus(1, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("post-reset outputs A", 32'(getAct(0)), 0);
    checkOutput("post-reset outputs B", 32'(getAct(1)), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("keyless start roundExt A", 32'(ifA.outIntRoundRegExtWr), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("keyless start busy A", 32'(ifA.outBusy), 0);

    $display("[TB] back-to-back decrypts with one key");
    applyStimulus(1, 0, 0, 0);
    captureOp(1);
    trace1 = traceCur;
    checkOutput("trace1 length", 32'(trace1.size()), 17);
    applyStimulus(0, 1, 1, 0);
    checkOutput("reuse start roundExt A", 32'(ifA.outIntRoundRegExtWr), 0);
    checkOutput("reuse start roundExt B", 32'(ifB.outIntRoundRegExtWr), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reuse start busy A", 32'(ifA.outBusy), 0);
    checkOutput("reuse start busy B", 32'(ifB.outBusy), 0);
    applyStimulus(1, 0, 0, 0);
    captureOp(1);
    checkOutput("trace2 length", 32'(traceCur.size()), 32'(trace1.size()));
    diffs = 0;
    for (int i = 0; i < traceCur.size() && i < trace1.size(); i++)
      if (traceCur[i] !== trace1[i]) diffs++;
    checkOutput("trace2 diffs", 32'(diffs), 0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
